i2s_xcvr: RTL and testbench

Parametrised successor to the fixed-format I2S transceiver between the PMOD codec pins and the effects pipe. It generates SCLK and LRCK from mclk and serialises and deserialises stereo I2S frames. Sample width, slot width and the mclk/SCLK ratio are parameters. It adds a channel-mode stage on RX (stereo, mono-left, mono-right, mono-sum) and TX underrun detection. It runs entirely in the mclk domain and feeds eff_pipe through a valid-strobe interface.

---
 rtl/i2s_xcvr.sv | 182 ++++++++++++++++++
 tb/tb_i2s_xcvr.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/i2s_xcvr.sv
// I2S transceiver: SCLK/LRCK generation, stereo TX/RX framing,
// RX channel-mode stage and TX underrun detection, all in the mclk domain.
module i2s_xcvr #(
    parameter int DATA_W   = 24,
    parameter int SLOT_W   = 32,
    parameter int SCLK_DIV = 4
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] rx_data_l,
    output logic [DATA_W-1:0] rx_data_r,
    output logic              rx_vld,
    input  logic [DATA_W-1:0] tx_data_l,
    input  logic [DATA_W-1:0] tx_data_r,
    input  logic              tx_vld,
    output logic              tx_underrun,
    output logic              lrck,
    output logic              sclk,
    input  logic              sdi,
    output logic              sdo
);

    localparam int FRAME = 2 * SLOT_W;
    localparam int BW    = $clog2(FRAME);
    localparam int CW    = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;

    logic [CW-1:0]     div_cnt;
    logic [BW-1:0]     b;
    logic [BW-1:0]     b_next;
    logic              rise;
    logic              fall;
    logic              load;
    logic              lrck_next;
    logic              in_l;
    logic              in_r;
    logic              cap;

    logic [DATA_W-1:0] hold_l;
    logic [DATA_W-1:0] hold_r;
    logic              written;
    logic [DATA_W-1:0] tx_l;
    logic [DATA_W-1:0] tx_r;
    logic [DATA_W-1:0] ld_l;
    logic [DATA_W-1:0] ld_r;
    logic [DATA_W-1:0] src_l;
    logic [DATA_W-1:0] src_r;

    logic [DATA_W-1:0] sh_l;
    logic [DATA_W-1:0] sh_r;
    logic [DATA_W-1:0] r_full;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] m_l;
    logic [DATA_W-1:0] m_r;

    // Serial bit for frame position pos; pad positions carry 0.
    function automatic logic pick(input int pos,
                                  input logic [DATA_W-1:0] l,
                                  input logic [DATA_W-1:0] r);
        logic bit_v;
        bit_v = 1'b0;
        if (pos < DATA_W)
            bit_v = l[DATA_W-1-pos];
        else if (pos >= SLOT_W && pos < SLOT_W + DATA_W)
            bit_v = r[DATA_W-1-(pos-SLOT_W)];
        return bit_v;
    endfunction

    always_comb begin
        int bi;
        int bni;
        rise      = (int'(div_cnt) == SCLK_DIV / 2 - 1);
        fall      = (int'(div_cnt) == SCLK_DIV - 1);
        bi        = int'(b);
        b_next    = (bi == FRAME - 1) ? '0 : b + 1'b1;
        bni       = int'(b_next);
        load      = fall && (bi == FRAME - 1);
        lrck_next = (bni >= SLOT_W - 1) && (bni <= FRAME - 2);
        in_l      = (bi < DATA_W);
        in_r      = (bi >= SLOT_W) && (bi < SLOT_W + DATA_W);
        cap       = rise && (bi == SLOT_W + DATA_W - 1);
    end

    // A tx_vld landing on the load cycle bypasses the holding register.
    always_comb begin
        ld_l  = tx_vld ? tx_data_l : hold_l;
        ld_r  = tx_vld ? tx_data_r : hold_r;
        src_l = load ? ld_l : tx_l;
        src_r = load ? ld_r : tx_r;
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            b       <= '0;
            sclk    <= 1'b0;
            lrck    <= 1'b0;
            sdo     <= 1'b0;
        end else begin
            div_cnt <= fall ? '0 : div_cnt + 1'b1;
            if (rise)
                sclk <= 1'b1;
            if (fall) begin
                sclk <= 1'b0;
                b    <= b_next;
                lrck <= lrck_next;
                sdo  <= pick(int'(b_next), src_l, src_r);
            end
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            hold_l      <= '0;
            hold_r      <= '0;
            written     <= 1'b1;
            tx_l        <= '0;
            tx_r        <= '0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= load && !tx_vld && !written;
            if (tx_vld) begin
                hold_l <= tx_data_l;
                hold_r <= tx_data_r;
            end
            if (load) begin
                tx_l    <= ld_l;
                tx_r    <= ld_r;
                written <= 1'b0;
            end else if (tx_vld) begin
                written <= 1'b1;
            end
        end
    end

    // Right word including the bit sampled this cycle.
    always_comb begin
        r_full = {sh_r[DATA_W-2:0], sdi};
        sum    = {sh_l[DATA_W-1], sh_l} + {r_full[DATA_W-1], r_full};
        m_l    = sh_l;
        m_r    = r_full;
        unique case (mode)
            2'd0: begin
                m_l = sh_l;
                m_r = r_full;
            end
            2'd1: begin
                m_l = sh_l;
                m_r = sh_l;
            end
            2'd2: begin
                m_l = r_full;
                m_r = r_full;
            end
            2'd3: begin
                m_l = sum[DATA_W:1];
                m_r = sum[DATA_W:1];
            end
        endcase
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            sh_l      <= '0;
            sh_r      <= '0;
            rx_vld    <= 1'b0;
            rx_data_l <= '0;
            rx_data_r <= '0;
        end else begin
            rx_vld <= cap;
            if (rise && in_l)
                sh_l <= {sh_l[DATA_W-2:0], sdi};
            if (rise && in_r)
                sh_r <= r_full;
            if (cap) begin
                rx_data_l <= m_l;
                rx_data_r <= m_r;
            end
        end
    end

endmodule

// File: tb/tb_i2s_xcvr.sv
// Directed loopback bench for i2s_xcvr: framing timing, channel modes,
// underrun/bypass handling and asynchronous reset.
module tb_i2s_xcvr;

    logic        mclk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] rx_data_l;
    logic [23:0] rx_data_r;
    logic        rx_vld;
    logic [23:0] tx_data_l = '0;
    logic [23:0] tx_data_r = '0;
    logic        tx_vld = 1'b0;
    logic        tx_underrun;
    logic        lrck;
    logic        sclk;
    logic        sdi;
    logic        sdo;

    int n_run = 0;
    int n_fail = 0;
    int tcyc = 0;

    i2s_xcvr #(.DATA_W(24), .SLOT_W(32), .SCLK_DIV(4)) dut (
        .mclk(mclk),
        .rst(rst),
        .mode(mode),
        .rx_data_l(rx_data_l),
        .rx_data_r(rx_data_r),
        .rx_vld(rx_vld),
        .tx_data_l(tx_data_l),
        .tx_data_r(tx_data_r),
        .tx_vld(tx_vld),
        .tx_underrun(tx_underrun),
        .lrck(lrck),
        .sclk(sclk),
        .sdi(sdi),
        .sdo(sdo)
    );

    assign sdi = sdo;

    always #5 mclk = ~mclk;

    // Reference position: mclk edges since reset release.
    always @(posedge mclk or posedge rst) begin
        if (rst) tcyc <= 0;
        else     tcyc <= tcyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %h expected %h",
                     name, $time, act, exp);
        end
    endtask

    // Pad slots must always be silent.
    always @(negedge mclk) begin
        int bb;
        bb = (tcyc / 4) % 64;
        if (!rst && ((bb >= 24 && bb <= 31) || bb >= 56))
            check("sdo_pad", {31'd0, sdo}, 32'd0);
    end

    task automatic run_frame(output logic [23:0] l, output logic [23:0] r,
                             output int und);
        bit seen;
        seen = 0;
        und = 0;
        l = '0;
        r = '0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge mclk);
            if (tx_underrun) und++;
            if (rx_vld) begin
                seen = 1;
                l = rx_data_l;
                r = rx_data_r;
            end
        end
        if (!seen) check("rx_vld_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [1:0] m, input logic [23:0] l,
                        input logic [23:0] r);
        mode = m;
        tx_data_l = l;
        tx_data_r = r;
        tx_vld = 1'b1;
        @(negedge mclk);
        tx_vld = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [23:0] l;
        logic [23:0] r;
        logic [23:0] el;
        logic [23:0] er;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [23:0] gl;
        logic [23:0] gr;
        int und;
        int p;
        int bb;

        vecs[0] = '{2'd0, 24'h123456, 24'hABCDEF, 24'h123456, 24'hABCDEF};
        vecs[1] = '{2'd3, 24'h400000, 24'h200000, 24'h300000, 24'h300000};
        vecs[2] = '{2'd3, 24'h800000, 24'h800000, 24'h800000, 24'h800000};
        vecs[3] = '{2'd3, 24'h7FFFFF, 24'h000001, 24'h400000, 24'h400000};
        vecs[4] = '{2'd1, 24'h000001, 24'hFFFFFF, 24'h000001, 24'h000001};
        vecs[5] = '{2'd2, 24'h000001, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
        vecs[6] = '{2'd3, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'hFFFFFF};
        vecs[7] = '{2'd3, 24'h000001, 24'h000000, 24'h000000, 24'h000000};

        #2 rst = 1'b1;
        repeat (3) @(negedge mclk);
        check("rst_rx_l", {8'd0, rx_data_l}, 32'd0);
        check("rst_rx_r", {8'd0, rx_data_r}, 32'd0);
        check("rst_rx_vld", {31'd0, rx_vld}, 32'd0);
        check("rst_underrun", {31'd0, tx_underrun}, 32'd0);
        check("rst_lrck", {31'd0, lrck}, 32'd0);
        check("rst_sclk", {31'd0, sclk}, 32'd0);
        check("rst_sdo", {31'd0, sdo}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 300; i++) begin
            @(negedge mclk);
            p = tcyc;
            bb = (p / 4) % 64;
            check("sclk_timing", {31'd0, sclk}, {31'd0, (p % 4) >= 2});
            check("lrck_timing", {31'd0, lrck},
                  {31'd0, (bb >= 31 && bb <= 62)});
            check("rx_vld_timing", {31'd0, rx_vld},
                  {31'd0, (p % 256) == 222});
            check("frame0_underrun", {31'd0, tx_underrun}, 32'd0);
        end

        foreach (vecs[v]) begin
            run_frame(gl, gr, und);
            send(vecs[v].mode, vecs[v].l, vecs[v].r);
            run_frame(gl, gr, und);
            check($sformatf("vec%0d_l", v), {8'd0, gl}, {8'd0, vecs[v].el});
            check($sformatf("vec%0d_r", v), {8'd0, gr}, {8'd0, vecs[v].er});
            check($sformatf("vec%0d_underrun", v), und, 0);
        end

        run_frame(gl, gr, und);
        send(2'd0, 24'h5A5A5A, 24'h0F0F0F);
        for (int f = 0; f < 4; f++) begin
            run_frame(gl, gr, und);
            check($sformatf("urun%0d_count", f), und, (f == 0) ? 1'b0 : 1'b1);
            check($sformatf("urun%0d_l", f), {8'd0, gl}, 32'h005A5A5A);
            check($sformatf("urun%0d_r", f), {8'd0, gr}, 32'h000F0F0F);
        end

        for (int i = 0; i < 300 && (tcyc % 256) != 255; i++)
            @(negedge mclk);
        check("bypass_align", tcyc % 256, 255);
        send(2'd0, 24'hC3C3C3, 24'h3C3C3C);
        check("bypass_no_underrun", {31'd0, tx_underrun}, 32'd0);
        run_frame(gl, gr, und);
        check("bypass_window_underrun", und, 0);
        check("bypass_l", {8'd0, gl}, 32'h00C3C3C3);
        check("bypass_r", {8'd0, gr}, 32'h003C3C3C);

        for (int i = 0; i < 300 && (tcyc % 256) != 160; i++)
            @(negedge mclk);
        check("mid_align_lrck", {31'd0, lrck}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_rx_l", {8'd0, rx_data_l}, 32'd0);
        check("mid_rst_rx_r", {8'd0, rx_data_r}, 32'd0);
        check("mid_rst_lrck", {31'd0, lrck}, 32'd0);
        check("mid_rst_sclk", {31'd0, sclk}, 32'd0);
        check("mid_rst_sdo", {31'd0, sdo}, 32'd0);
        check("mid_rst_vld", {31'd0, rx_vld}, 32'd0);
        repeat (3) @(negedge mclk);
        rst = 1'b0;
        run_frame(gl, gr, und);
        check("post_rst_rx_vld_pos", tcyc, 222);
        check("post_rst_rx_l", {8'd0, gl}, 32'd0);
        check("post_rst_underrun", und, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
